// File: rtl/openram_gpio_scan_master_if.sv
// Host/chip signal bundle for openram_gpio_scan_master.
//   master modport : the scan master (drives cmd_ready, rsp_*, busy and the chip strobes)
//   slave modport  : the far side (command source, response sink and the testchip pins)
// Host side : cmd_valid/cmd_ready/cmd_data, rsp_valid/rsp_ready/rsp_data/rsp_mismatch, busy
// Chip side : gpio_in, gpio_scan, gpio_sram_load, global_csb (to chip), gpio_out (from chip)
interface openram_gpio_scan_master_if #(
  parameter int unsigned PacketWidth = 112
) ();
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [PacketWidth-1:0] cmd_data;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [PacketWidth-1:0] rsp_data;
  logic                   rsp_mismatch;
  logic                   busy;
  logic                   gpio_in;
  logic                   gpio_scan;
  logic                   gpio_sram_load;
  logic                   global_csb;
  logic                   gpio_out;

  modport master (
    input  cmd_valid, cmd_data, rsp_ready, gpio_out,
    output cmd_ready, rsp_valid, rsp_data, rsp_mismatch, busy,
    output gpio_in, gpio_scan, gpio_sram_load, global_csb
  );

  modport slave (
    output cmd_valid, cmd_data, rsp_ready, gpio_out,
    input  cmd_ready, rsp_valid, rsp_data, rsp_mismatch, busy,
    input  gpio_in, gpio_scan, gpio_sram_load, global_csb
  );
endinterface

// File: rtl/openram_gpio_scan_master.sv
// Host-side driver for the OpenRAM testchip GPIO scan port.
// Takes one parallel command packet, shifts it MSB-first into the chip, pulses global_csb low
// for one cycle, pulses gpio_sram_load, waits SettleCycles, then shifts the result packet back.
// Ports:
//   clk_i     : sole clock, rising edge
//   resetn_i  : synchronous reset, active-low
//   bus_io    : master modport of openram_gpio_scan_master_if (host handshake + chip pins)
// Packet layout (112 bits):
//   {sel[3:0], addr0[15:0], din0[31:0], csb0, web0, wmask0[3:0],
//    addr1[15:0], din1[31:0], csb1, web1, wmask1[3:0]}
// Optional build macro GPIO_SCAN_CHECK_EN: when defined, rsp_mismatch flags any returned
// non-data field that differs from the command sent; otherwise rsp_mismatch is tied low.
// Latency from accept edge to rsp_valid is 2*PacketWidth + 2 + SettleCycles + 1 cycles; the
// final cycle is the transfer of the captured packet into the stable response register.
module openram_gpio_scan_master #(
  parameter int unsigned PacketWidth  = 112,
  parameter int unsigned SettleCycles = 1
) (
  input logic                        clk_i,
  input logic                        resetn_i,
  openram_gpio_scan_master_if.master bus_io
);

  localparam int unsigned   CntW       = $clog2(PacketWidth);
  localparam logic [CntW-1:0] LastBit    = CntW'(PacketWidth - 1);
  localparam logic [CntW-1:0] LastSettle = CntW'(SettleCycles - 1);

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StExec,
    StLoad,
    StSettle,
    StCapture,
    StResp
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [PacketWidth-1:0] cmd_q, cmd_d;
  logic [PacketWidth-1:0] cap_q, cap_d;
  logic [PacketWidth-1:0] rsp_data_q, rsp_data_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_mismatch_q, rsp_mismatch_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   busy_q, busy_d;
  logic                   gpio_in_q, gpio_in_d;
  logic                   gpio_scan_q, gpio_scan_d;
  logic                   gpio_load_q, gpio_load_d;
  logic                   global_csb_q, global_csb_d;
  logic                   mismatch;

`ifdef GPIO_SCAN_CHECK_EN
  // Control/address fields only; din0 [91:60] and din1 [37:6] carry read data and are skipped.
  localparam logic [111:0] CheckMask = {{20{1'b1}}, {32{1'b0}}, {22{1'b1}}, {32{1'b0}}, {6{1'b1}}};
  assign mismatch = ((cap_q ^ cmd_q) & CheckMask) != '0;
`else
  assign mismatch = 1'b0;
`endif

  // Sequencing.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cmd_d          = cmd_q;
    cap_d          = cap_q;
    rsp_data_d     = rsp_data_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_mismatch_d = rsp_mismatch_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.cmd_valid && cmd_ready_q) begin
          cmd_d   = bus_io.cmd_data;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q == LastBit) begin
          cnt_d   = '0;
          state_d = StExec;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StExec: state_d = StLoad;
      StLoad: begin
        cnt_d   = '0;
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == LastSettle) begin
          cnt_d   = '0;
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCapture: begin
        // Chip shifts on this same edge, so gpio_out still shows the bit for this index.
        cap_d[LastBit - cnt_q] = bus_io.gpio_out;
        if (cnt_q == LastBit) begin
          cnt_d   = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (!rsp_valid_q) begin
          // Publish once; rsp_data then stays put however long the consumer stalls.
          rsp_valid_d    = 1'b1;
          rsp_data_d     = cap_q;
          rsp_mismatch_d = mismatch;
        end else if (bus_io.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pin outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    cmd_ready_d  = (state_d == StIdle);
    busy_d       = (state_d != StIdle);
    gpio_scan_d  = (state_d == StShift) || (state_d == StCapture);
    gpio_in_d    = (state_d == StShift) ? cmd_d[LastBit - cnt_d] : 1'b0;
    gpio_load_d  = (state_d == StLoad);
    global_csb_d = (state_d != StExec);
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      cmd_q          <= '0;
      cap_q          <= '0;
      rsp_data_q     <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_mismatch_q <= 1'b0;
      cmd_ready_q    <= 1'b0;
      busy_q         <= 1'b0;
      gpio_in_q      <= 1'b0;
      gpio_scan_q    <= 1'b0;
      gpio_load_q    <= 1'b0;
      global_csb_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cmd_q          <= cmd_d;
      cap_q          <= cap_d;
      rsp_data_q     <= rsp_data_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_mismatch_q <= rsp_mismatch_d;
      cmd_ready_q    <= cmd_ready_d;
      busy_q         <= busy_d;
      gpio_in_q      <= gpio_in_d;
      gpio_scan_q    <= gpio_scan_d;
      gpio_load_q    <= gpio_load_d;
      global_csb_q   <= global_csb_d;
    end
  end

  assign bus_io.cmd_ready      = cmd_ready_q;
  assign bus_io.busy           = busy_q;
  assign bus_io.rsp_valid      = rsp_valid_q;
  assign bus_io.rsp_data       = rsp_data_q;
  assign bus_io.rsp_mismatch   = rsp_mismatch_q;
  assign bus_io.gpio_in        = gpio_in_q;
  assign bus_io.gpio_scan      = gpio_scan_q;
  assign bus_io.gpio_sram_load = gpio_load_q;
  assign bus_io.global_csb     = global_csb_q;

endmodule
